// File: rtl/clut_write_ctrl.sv
// clut_write_ctrl: queues palette writes and drains them into the CLUT write port only while blanked
// Build option: define CLUT_VBLANK_ONLY_EN to drain during vertical blanking only.
module clut_write_ctrl #(
   parameter int CIDXW = 4,
   parameter int COLRW = 12,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int PW = AW + 1
) (
   input  logic             clk_25MHz,
   input  logic             btn_rst_n,
   input  logic             bright,
   input  logic             vblank,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [CIDXW-1:0] req_addr,
   input  logic [COLRW-1:0] req_data,
   output logic             clut_we,
   output logic [CIDXW-1:0] clut_addr_write,
   output logic [COLRW-1:0] clut_data_in,
   output logic [PW-1:0]    pending,
   output logic             busy
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WAIT  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [PW-1:0] FULL = PW'(DEPTH);
   logic [CIDXW-1:0] addr_mem [DEPTH];
   logic [COLRW-1:0] data_mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [1:0] state, state_n;
   logic [PW-1:0] count_n;
   logic win, push, pop;
`ifdef CLUT_VBLANK_ONLY_EN
   assign win = vblank && !bright;
`else
   logic unused_vblank;
   assign unused_vblank = vblank;
   assign win = !bright;
`endif
   assign req_ready = pending != FULL;
   assign push = req_valid && req_ready;
   assign pop = (state != IDLE) && win;
   assign busy = (pending != '0) || clut_we;
   // occupancy and next state; a non-idle state always implies a non-empty FIFO
   always_comb begin
      count_n = pending + PW'(push) - PW'(pop);
      state_n = (count_n == '0) ? IDLE : (win ? DRAIN : WAIT);
   end
   // FIFO pointers, occupancy and control state
   always_ff @(posedge clk_25MHz or negedge btn_rst_n) begin
      if (!btn_rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         pending <= '0;
         state   <= IDLE;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         pending <= count_n;
         state   <= state_n;
      end
   end
   // entry storage needs no reset: occupancy alone decides what is valid
   always_ff @(posedge clk_25MHz) begin
      if (push) begin
         addr_mem[wr_ptr] <= req_addr;
         data_mem[wr_ptr] <= req_data;
      end
   end
   // registered CLUT write port: one strobe per pop, address/data hold otherwise
   always_ff @(posedge clk_25MHz or negedge btn_rst_n) begin
      if (!btn_rst_n) begin
         clut_we         <= 1'b0;
         clut_addr_write <= '0;
         clut_data_in    <= '0;
      end else begin
         clut_we <= pop;
         if (pop) begin
            clut_addr_write <= addr_mem[rd_ptr];
            clut_data_in    <= data_mem[rd_ptr];
         end
      end
   end
endmodule

// File: tb/tb_clut_write_ctrl.sv
// tb_clut_write_ctrl: table-driven, directed and randomized checks against a queue-based model
module tb_clut_write_ctrl;
   localparam int CIDXW = 4;
   localparam int COLRW = 12;
   localparam int DEPTH = 4;
   localparam int PW = $clog2(DEPTH) + 1;
   typedef struct packed {
      logic [CIDXW-1:0] a;
      logic [COLRW-1:0] d;
   } ent_t;
   typedef struct {
      int n_push;
      int open;
      int exp_strobes;
      int exp_pending;
   } vec_t;
   logic clk_25MHz = 1'b0;
   logic btn_rst_n = 1'b0;
   logic bright = 1'b1;
   logic vblank = 1'b1;
   logic req_valid = 1'b0;
   logic [CIDXW-1:0] req_addr = '0;
   logic [COLRW-1:0] req_data = '0;
   logic req_ready, clut_we, busy;
   logic [CIDXW-1:0] clut_addr_write;
   logic [COLRW-1:0] clut_data_in;
   logic [PW-1:0] pending;
   int n_chk = 0;
   int n_fail = 0;
   ent_t q[$];
   logic m_we = 1'b0;
   logic [CIDXW-1:0] m_addr = '0;
   logic [COLRW-1:0] m_data = '0;
   bit m_acc;
   vec_t tbl[6];
   clut_write_ctrl #(.CIDXW(CIDXW), .COLRW(COLRW), .DEPTH(DEPTH)) dut (
      .clk_25MHz(clk_25MHz), .btn_rst_n(btn_rst_n), .bright(bright), .vblank(vblank),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
      .clut_we(clut_we), .clut_addr_write(clut_addr_write), .clut_data_in(clut_data_in),
      .pending(pending), .busy(busy)
   );
   always #20 clk_25MHz = ~clk_25MHz;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // one clock: predict from the drain rules, advance, compare every output
   task automatic tick();
      bit rdy, win;
      ent_t e;
      rdy = q.size() != DEPTH;
      chk("req_ready", {31'd0, req_ready}, {31'd0, rdy});
`ifdef CLUT_VBLANK_ONLY_EN
      win = vblank && !bright;
`else
      win = !bright;
`endif
      if (win && q.size() != 0) begin
         e = q.pop_front();
         m_we = 1'b1;
         m_addr = e.a;
         m_data = e.d;
      end else m_we = 1'b0;
      m_acc = req_valid && rdy;
      if (m_acc) q.push_back('{a: req_addr, d: req_data});
      @(posedge clk_25MHz);
      #1;
      chk("clut_we", {31'd0, clut_we}, {31'd0, m_we});
      chk("clut_addr", 32'(clut_addr_write), 32'(m_addr));
      chk("clut_data", 32'(clut_data_in), 32'(m_data));
      chk("pending", 32'(pending), q.size());
      chk("busy", {31'd0, busy}, {31'd0, q.size() != 0 || m_we});
   endtask
   task automatic do_reset();
      btn_rst_n = 1'b0;
      req_valid = 1'b0;
      @(posedge clk_25MHz);
      #1;
      btn_rst_n = 1'b1;
      q.delete();
      m_we = 1'b0;
      m_addr = '0;
      m_data = '0;
      chk("rst_we", {31'd0, clut_we}, 32'd0);
      chk("rst_addr", 32'(clut_addr_write), 32'd0);
      chk("rst_data", 32'(clut_data_in), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
   endtask
   task automatic push_n(input int n, input int base);
      for (int k = 0; k < n; k++) begin
         req_valid = 1'b1;
         req_addr = CIDXW'(base + k);
         req_data = COLRW'((base + k) * 'h111);
         tick();
      end
      req_valid = 1'b0;
   endtask
   initial begin
      int s;
      ent_t seen[$];
      tbl[0] = '{4, 2, 2, 2};
      tbl[1] = '{4, 0, 0, 4};
      tbl[2] = '{3, 5, 3, 0};
      tbl[3] = '{1, 1, 1, 0};
      tbl[4] = '{4, 4, 4, 0};
      tbl[5] = '{2, 3, 2, 0};
      #5;
      do_reset();
      // window-length table: strobes = min(queued, open cycles), rest stays pending
      foreach (tbl[i]) begin
         do_reset();
         bright = 1'b1;
         vblank = 1'b1;
         push_n(tbl[i].n_push, i + 1);
         s = 0;
         bright = 1'b0;
         for (int c = 0; c < tbl[i].open; c++) begin tick(); s += int'(clut_we); end
         bright = 1'b1;
         for (int c = 0; c < 2; c++) begin tick(); s += int'(clut_we); end
         chk($sformatf("tbl%0d_strobes", i), s, tbl[i].exp_strobes);
         chk($sformatf("tbl%0d_pending", i), 32'(pending), tbl[i].exp_pending);
         bright = 1'b0;
         for (int c = 0; c < 6; c++) tick();
         chk($sformatf("tbl%0d_drained", i), 32'(pending), 32'd0);
      end
      // reset in the middle of a drain
      do_reset();
      bright = 1'b1;
      push_n(3, 1);
      bright = 1'b0;
      for (int c = 0; c < 4 && !clut_we; c++) tick();
      chk("middrain_strobe_seen", {31'd0, clut_we}, 32'd1);
      btn_rst_n = 1'b0;
      #1;
      chk("middrain_we_async", {31'd0, clut_we}, 32'd0);
      chk("middrain_pending_async", 32'(pending), 32'd0);
      do_reset();
      s = 0;
      for (int c = 0; c < 10; c++) begin tick(); s += int'(clut_we); end
      chk("middrain_no_strobes", s, 32'd0);
      // backpressure: fifth request held until the window opens, then 1..5 in order
      do_reset();
      bright = 1'b1;
      push_n(4, 1);
      req_valid = 1'b1;
      req_addr = 4'd5;
      req_data = 12'h555;
      for (int c = 0; c < 3; c++) tick();
      chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
      chk("bp_pending_full", 32'(pending), 32'd4);
      seen.delete();
      bright = 1'b0;
      m_acc = 1'b0;
      for (int c = 0; c < 10 && !m_acc; c++) begin
         tick();
         if (clut_we) seen.push_back('{a: clut_addr_write, d: clut_data_in});
      end
      chk("bp_fifth_accepted", {31'd0, m_acc}, 32'd1);
      req_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (clut_we) seen.push_back('{a: clut_addr_write, d: clut_data_in});
      end
      chk("bp_strobe_count", seen.size(), 32'd5);
      foreach (seen[i]) chk($sformatf("bp_order%0d", i), 32'(seen[i].a), i + 1);
      // same index twice: both issue on consecutive cycles, last value wins
      do_reset();
      bright = 1'b0;
      req_valid = 1'b1;
      req_addr = 4'd2;
      req_data = 12'h111;
      tick();
      req_data = 12'hF00;
      tick();
      req_valid = 1'b0;
      chk("lw_first", 32'(clut_data_in), 32'h111);
      chk("lw_first_we", {31'd0, clut_we}, 32'd1);
      tick();
      chk("lw_second", 32'(clut_data_in), 32'hF00);
      chk("lw_second_we", {31'd0, clut_we}, 32'd1);
      // full with a simultaneous pop: refused this cycle, accepted the next
      do_reset();
      bright = 1'b1;
      push_n(4, 8);
      bright = 1'b0;
      req_valid = 1'b1;
      req_addr = 4'hC;
      req_data = 12'hABC;
      tick();
      chk("full_pop_refused", {31'd0, m_acc}, 32'd0);
      chk("full_pop_pending", 32'(pending), 32'd3);
      tick();
      chk("full_pop_accept", {31'd0, m_acc}, 32'd1);
      req_valid = 1'b0;
      for (int c = 0; c < 6; c++) tick();
`ifdef CLUT_VBLANK_ONLY_EN
      do_reset();
      bright = 1'b0;
      vblank = 1'b0;
      push_n(1, 7);
      s = 0;
      for (int c = 0; c < 100; c++) begin tick(); s += int'(clut_we); end
      chk("vb_no_strobe", s, 32'd0);
      vblank = 1'b1;
      tick();
      chk("vb_strobe", {31'd0, clut_we}, 32'd1);
      chk("vb_addr", 32'(clut_addr_write), 32'd7);
`endif
      // randomized traffic with blanking in runs
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) bright = ~bright;
         vblank = $urandom_range(0, 2) != 0;
         req_valid = $urandom_range(0, 1) == 1;
         req_addr = CIDXW'($urandom);
         req_data = COLRW'($urandom);
         tick();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
